// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// req/gnt + rvalid bus and hands it to decode with a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned SEL_PC_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [31:0]             imem_rdata,
  output logic [31:0]             code,
  output logic [31:0]             pc,
  output logic                    code_valid,
  input  logic                    code_ready,
  input  logic [SEL_PC_WIDTH-1:0] pc_sel,
  input  logic [31:0]             imm,
  input  logic [31:0]             rs1_data,
  input  logic                    br_taken,
  output logic                    fetch_fault,
  output logic [31:0]             fault_pc,
  output logic [31:0]             retire_cnt
);

  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_ADD4 = SEL_PC_WIDTH'(0);
  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JAL  = SEL_PC_WIDTH'(1);
  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JALR = SEL_PC_WIDTH'(2);
  localparam logic [6:0]              OPC_BRANCH  = 7'b1100011;
  // Counter value on the last S_WAIT cycle before the timeout fires.
  localparam logic [7:0]              TMO_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [31:0] next_pc;
  logic [31:0] jalr_sum;

  assign imem_addr = pc;
  assign jalr_sum  = rs1_data + imm;

  always_comb begin
    next_pc = pc + 32'd4;
    case (pc_sel)
      SEL_PC_JAL:  next_pc = pc + imm;
      SEL_PC_JALR: next_pc = {jalr_sum[31:1], 1'b0};
      SEL_PC_ADD4: if (code[6:0] == OPC_BRANCH && br_taken) next_pc = pc + imm;
      default:     next_pc = pc + 32'd4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      code        <= '0;
      code_valid  <= 1'b0;
      imem_req    <= 1'b1;
      fetch_fault <= 1'b0;
      fault_pc    <= '0;
      retire_cnt  <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            state    <= S_WAIT;
            imem_req <= 1'b0;
            tmo_cnt  <= '0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            code       <= imem_rdata;
            code_valid <= 1'b1;
            state      <= S_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_cnt == TMO_LAST) begin
              fetch_fault <= 1'b1;
              fault_pc    <= pc;
              state       <= S_FAULT;
            end
          end
        end
        S_HOLD: begin
          if (code_ready) begin
            retire_cnt <= retire_cnt + 32'd1;
            code_valid <= 1'b0;
            // A misaligned target still retires the instruction but keeps pc
            // pointing at it so fault_pc/pc together identify the culprit.
            if (next_pc[1]) begin
              fetch_fault <= 1'b1;
              fault_pc    <= next_pc;
              state       <= S_FAULT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          imem_req   <= 1'b0;
          code_valid <= 1'b0;
        end
        default: state <= S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a hand-driven memory responder and fixed
// next-PC vectors with hand-computed addresses.
module tb_fetch_unit;

  localparam logic [1:0] ADD4 = 2'd0;
  localparam logic [1:0] JAL  = 2'd1;
  localparam logic [1:0] JALR = 2'd2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BRANCH = 32'h0000_0063;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] code;
  logic [31:0] pc;
  logic        code_valid;
  logic        code_ready;
  logic [1:0]  pc_sel;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        br_taken;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] retire_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(255), .SEL_PC_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .code(code), .pc(pc), .code_valid(code_valid), .code_ready(code_ready),
    .pc_sel(pc_sel), .imm(imm), .rs1_data(rs1_data), .br_taken(br_taken),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc), .retire_cnt(retire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Grants the pending request, offers a junk rvalid alongside the grant
  // (must be ignored), then returns the real word; ends in S_HOLD.
  task automatic serve(input logic [31:0] exp_addr, input logic [31:0] word, output int req_cyc);
    int w = 0;
    while (imem_req !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
    chk("imem_addr", imem_addr, exp_addr);
    req_cyc     = cyc;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = ~word;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    chk("code_valid", {31'b0, code_valid}, 32'd1);
    chk("code", code, word);
    chk("pc", pc, exp_addr);
  endtask

  task automatic retire(input logic [1:0] sel, input logic [31:0] im, input logic [31:0] rs1,
                        input logic br);
    pc_sel     = sel;
    imm        = im;
    rs1_data   = rs1;
    br_taken   = br;
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    br_taken   = 1'b0;
    exp_ret    = exp_ret + 32'd1;
    chk("retire_cnt", retire_cnt, exp_ret);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_code", code, 32'h0);
    chk("rst_valid", {31'b0, code_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_retire", retire_cnt, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    rst_n   = 1'b1;
    exp_ret = '0;
  endtask

  initial begin
    int t0, t1, t2, tn;
    int i;
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    code_ready = 1'b0; pc_sel = ADD4; imm = '0; rs1_data = '0; br_taken = 1'b0;
    exp_ret = '0;
    repeat (2) @(negedge clk);
    pulse_reset();

    // Back-to-back sequential fetch with code_ready held high.
    code_ready = 1'b1;
    pc_sel     = ADD4;
    serve(32'h0, NOP, t0);
    serve(32'h4, NOP, t1);
    serve(32'h8, NOP, t2);
    chk("tput_0_4", t1 - t0, 32'd3);
    chk("tput_4_8", t2 - t1, 32'd3);
    @(negedge clk);
    code_ready = 1'b0;
    exp_ret = 32'd3;
    chk("retire_3", retire_cnt, exp_ret);
    chk("addr_after_3", imem_addr, 32'hC);

    serve(32'hC, NOP, tn);
    retire(ADD4, 32'h0, 32'h0, 1'b0);
    chk("addr_add4", imem_addr, 32'h10);

    serve(32'h10, 32'h0000_006F, tn);
    retire(JAL, 32'hFFFF_FFF0, 32'h0, 1'b0);
    chk("addr_jal_back", imem_addr, 32'h0);

    serve(32'h0, 32'h0000_0067, tn);
    retire(JALR, 32'h4, 32'h101, 1'b0);
    chk("addr_jalr", imem_addr, 32'h104);

    serve(32'h104, NOP, tn);
    retire(JAL, 32'hFFFF_FF1C, 32'h0, 1'b0);
    chk("addr_jal_20", imem_addr, 32'h20);

    serve(32'h20, BRANCH, tn);
    retire(ADD4, 32'h8, 32'h0, 1'b1);
    chk("addr_br_taken", imem_addr, 32'h28);

    serve(32'h28, NOP, tn);
    retire(JAL, 32'hFFFF_FFF8, 32'h0, 1'b0);
    serve(32'h20, BRANCH, tn);
    retire(ADD4, 32'h8, 32'h0, 1'b0);
    chk("addr_br_not", imem_addr, 32'h24);

    // br_taken only matters for branch opcodes.
    serve(32'h24, NOP, tn);
    retire(ADD4, 32'h8, 32'h0, 1'b1);
    chk("addr_nonbr", imem_addr, 32'h28);

    // Decode stalls for 5 cycles.
    serve(32'h28, 32'h1234_5013, tn);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_code", code, 32'h1234_5013);
      chk("stall_pc", pc, 32'h28);
      chk("stall_valid", {31'b0, code_valid}, 32'd1);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    retire(ADD4, 32'h0, 32'h0, 1'b0);
    chk("stall_valid_drop", {31'b0, code_valid}, 32'd0);
    chk("stall_addr", imem_addr, 32'h2C);
    @(negedge clk);
    chk("stall_one_retire", retire_cnt, exp_ret);

    serve(32'h2C, NOP, tn);
    retire(JAL, 32'hFFFF_FFD0, 32'h0, 1'b0);
    chk("addr_top", imem_addr, 32'hFFFF_FFFC);
    serve(32'hFFFF_FFFC, NOP, tn);
    retire(ADD4, 32'h0, 32'h0, 1'b0);
    chk("addr_wrap", imem_addr, 32'h0);
    chk("wrap_nofault", {31'b0, fetch_fault}, 32'd0);

    // Misaligned JAL target.
    serve(32'h0, 32'h0000_006F, tn);
    retire(JAL, 32'h6, 32'h0, 1'b0);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h6);
    chk("mis_pc_kept", pc, 32'h0);
    imem_gnt = 1'b1; imem_rvalid = 1'b1; code_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fault_req", {31'b0, imem_req}, 32'd0);
      chk("fault_valid", {31'b0, code_valid}, 32'd0);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; code_ready = 1'b0;
    chk("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    chk("fault_retire", retire_cnt, exp_ret);

    // Response never arrives.
    pulse_reset();
    @(negedge clk);
    chk("tmo_req", {31'b0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    i = 1;
    while (fetch_fault !== 1'b1 && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("tmo_cycles", i, 32'd256);
    chk("tmo_fault_pc", fault_pc, 32'h0);
    chk("tmo_req_off", {31'b0, imem_req}, 32'd0);

    // Reset in the middle of S_WAIT, then a stale response.
    pulse_reset();
    serve(32'h0, NOP, tn);
    retire(ADD4, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_addr", imem_addr, 32'h4);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_req", {31'b0, imem_req}, 32'd1);
    chk("async_rst_ret", retire_cnt, 32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    exp_ret     = '0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0BAD;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    chk("stale_valid", {31'b0, code_valid}, 32'd0);
    chk("stale_code", code, 32'h0);
    chk("stale_req", {31'b0, imem_req}, 32'd1);
    chk("stale_addr", imem_addr, 32'h0);
    serve(32'h0, NOP, tn);
    retire(ADD4, 32'h0, 32'h0, 1'b0);
    chk("post_rst_addr", imem_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
